// File: rtl/mining_job_dispatcher.sv
// Host-side mining job dispatcher. Jobs are queued in a FIFO and launched one at a time into the miner.
// Each result (nonce, job id, timeout flag) is returned over a valid/ready port.
//
// state  | meaning
// IDLE   | miner held in reset, waiting for a queued job
// LOAD   | job registered onto miner inputs, reset held for RST_CYCLES
// RUN    | miner released, counting cycles toward TIMEOUT
// RESULT | result presented, miner frozen in reset until accepted
module mining_job_dispatcher #(
   parameter int               BYTE_W     = 8,
   parameter int               DEPTH      = 4,
   parameter int               RST_CYCLES = 2,
   parameter int               TMO_W      = 16,
   parameter logic [TMO_W-1:0] TIMEOUT    = 16'd60000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                job_valid,
   output logic                job_ready,
   input  logic [12*BYTE_W-1:0] job_block,
   input  logic [7:0]          job_target,
   output logic                miner_reset,
   output logic [12*BYTE_W-1:0] miner_data,
   output logic [7:0]          miner_target,
   input  logic                miner_finished,
   input  logic [31:0]         miner_nonce,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [31:0]         res_nonce,
   output logic [3:0]          res_id,
   output logic                res_timeout
);

   localparam int HDR_W = 12 * BYTE_W;
   localparam int ENT_W = 4 + 8 + HDR_W;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int LD_W  = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESULT} state_t;

   state_t            state, state_next;
   logic [ENT_W-1:0]  mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [3:0]        id_cnt;
   logic [3:0]        run_id;
   logic [LD_W-1:0]   ld_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              full, empty, push, pop;
   logic              launch, fin_hit, tmo_hit;
   logic [ENT_W-1:0]  head;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign job_ready = !full;
   assign push      = job_valid && !full;
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {id_cnt, job_target, job_block};
   end

   // Head stays queued while in flight, so occupancy covers the running job too.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         id_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            id_cnt <= id_cnt + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      launch      = 1'b0;
      pop         = 1'b0;
      fin_hit     = 1'b0;
      tmo_hit     = 1'b0;
      miner_reset = 1'b1;
      res_valid   = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               launch     = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (ld_cnt == LD_W'(1)) state_next = RUN;
         end
         RUN: begin
            miner_reset = 1'b0;
            // A find on the timeout cycle still counts as a find.
            if (miner_finished) begin
               fin_hit    = 1'b1;
               state_next = RESULT;
            end else if (tmo_cnt == TIMEOUT - TMO_W'(1)) begin
               tmo_hit    = 1'b1;
               state_next = RESULT;
            end
         end
         RESULT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               pop        = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         miner_data   <= '0;
         miner_target <= '0;
         run_id       <= '0;
         ld_cnt       <= '0;
         tmo_cnt      <= '0;
         res_nonce    <= '0;
         res_id       <= '0;
         res_timeout  <= 1'b0;
      end else begin
         if (launch) begin
            miner_data   <= head[HDR_W-1:0];
            miner_target <= head[HDR_W +: 8];
            run_id       <= head[ENT_W-1 -: 4];
            tmo_cnt      <= '0;
            ld_cnt       <= LD_W'(RST_CYCLES);
         end
         if (state == LOAD) ld_cnt  <= ld_cnt - 1'b1;
         if (state == RUN)  tmo_cnt <= tmo_cnt + 1'b1;
         if (fin_hit) begin
            res_nonce   <= miner_nonce;
            res_timeout <= 1'b0;
            res_id      <= run_id;
         end else if (tmo_hit) begin
            res_nonce   <= '0;
            res_timeout <= 1'b1;
            res_id      <= run_id;
         end
      end
   end

endmodule

// File: tb/tb_mining_job_dispatcher.sv
// Directed self-checking bench for mining_job_dispatcher, built with TIMEOUT=50.
// The miner is emulated by driving miner_finished/miner_nonce from the stimulus sequence.
module tb_mining_job_dispatcher;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [95:0] job_block = '0;
   logic [7:0]  job_target = '0;
   logic        miner_reset;
   logic [95:0] miner_data;
   logic [7:0]  miner_target;
   logic        miner_finished = 1'b0;
   logic [31:0] miner_nonce = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_nonce;
   logic [3:0]  res_id;
   logic        res_timeout;

   int checks   = 0;
   int failures = 0;

   mining_job_dispatcher #(
      .BYTE_W(8), .DEPTH(4), .RST_CYCLES(2), .TMO_W(16), .TIMEOUT(16'd50)
   ) dut (
      .clk(clk), .reset(reset),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_block(job_block), .job_target(job_target),
      .miner_reset(miner_reset), .miner_data(miner_data), .miner_target(miner_target),
      .miner_finished(miner_finished), .miner_nonce(miner_nonce),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_nonce(res_nonce), .res_id(res_id), .res_timeout(res_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input logic [95:0] obs, input logic [95:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_job(input logic [95:0] blk, input logic [7:0] tgt);
      job_valid  = 1'b1;
      job_block  = blk;
      job_target = tgt;
      tick();
      job_valid  = 1'b0;
   endtask

   task automatic wait_run(input string tag);
      for (int i = 0; i < 40 && miner_reset; i++) tick();
      chk(miner_reset, 1'b0, {tag, " reach_run"});
   endtask

   task automatic run_job(input logic [31:0] nonce, input int dly, input logic [3:0] eid,
                          input logic exp_rdy, input string tag);
      wait_run(tag);
      repeat (dly) tick();
      miner_finished = 1'b1;
      miner_nonce    = nonce;
      tick();
      miner_finished = 1'b0;
      chk(res_valid,   1'b1,    {tag, " valid"});
      chk(res_nonce,   nonce,   {tag, " nonce"});
      chk(res_id,      eid,     {tag, " id"});
      chk(res_timeout, 1'b0,    {tag, " timeout"});
      chk(miner_reset, 1'b1,    {tag, " miner_reset"});
      chk(job_ready,   exp_rdy, {tag, " job_ready"});
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk(res_valid, 1'b0, {tag, " valid_drop"});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, checked before any clock edge
      #2;
      chk(miner_reset,  1'b1, "rst miner_reset");
      chk(job_ready,    1'b1, "rst job_ready");
      chk(res_valid,    1'b0, "rst res_valid");
      chk(res_nonce,    32'h0, "rst res_nonce");
      chk(res_id,       4'h0, "rst res_id");
      chk(res_timeout,  1'b0, "rst res_timeout");
      chk(miner_data,   96'h0, "rst miner_data");
      chk(miner_target, 8'h0, "rst miner_target");
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Single job: reset falls two cycles after LOAD entry, find 20 cycles later
      push_job(96'h0123_4567_89AB_CDEF_0011_2233, 8'h10);
      tick();
      chk(miner_reset,  1'b1, "t1 load miner_reset");
      chk(miner_data,   96'h0123_4567_89AB_CDEF_0011_2233, "t1 miner_data");
      chk(miner_target, 8'h10, "t1 miner_target");
      tick();
      chk(miner_reset, 1'b1, "t1 load2 miner_reset");
      tick();
      chk(miner_reset, 1'b0, "t1 run miner_reset");
      repeat (20) tick();
      chk(res_valid, 1'b0, "t1 no early result");
      miner_finished = 1'b1;
      miner_nonce    = 32'h0000_0A5C;
      tick();
      miner_finished = 1'b0;
      chk(res_valid,   1'b1, "t1 valid");
      chk(res_nonce,   32'h0000_0A5C, "t1 nonce");
      chk(res_id,      4'h0, "t1 id");
      chk(res_timeout, 1'b0, "t1 timeout");
      chk(miner_reset, 1'b1, "t1 result miner_reset");
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk(res_valid, 1'b0, "t1 valid_drop");

      // Reset pulse, then fill the FIFO; fifth offer must be refused
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk(res_id, 4'h0, "t2 reset res_id");
      push_job(96'hA0, 8'h01);
      push_job(96'hA1, 8'h02);
      push_job(96'hA2, 8'h03);
      push_job(96'hA3, 8'h04);
      chk(job_ready, 1'b0, "t2 full job_ready");
      job_valid  = 1'b1;
      job_block  = 96'hA4;
      job_target = 8'h05;
      tick();
      job_valid = 1'b0;
      chk(job_ready, 1'b0, "t2 still full");
      run_job(32'h1000, 3, 4'd0, 1'b0, "t2 job0");
      chk(job_ready, 1'b1, "t2 ready after first handshake");
      chk(miner_data, 96'hA0, "t2 job0 data");
      run_job(32'h1001, 4, 4'd1, 1'b1, "t2 job1");
      run_job(32'h1002, 5, 4'd2, 1'b1, "t2 job2");
      run_job(32'h1003, 6, 4'd3, 1'b1, "t2 job3");
      chk(miner_data, 96'hA3, "t2 job3 data");
      repeat (6) tick();
      chk(miner_reset, 1'b1, "t2 refused job never launched");

      // Timeout after 50 RUN cycles, with the next job already queued
      push_job(96'hB0, 8'h11);
      push_job(96'hB1, 8'h12);
      wait_run("t3 job4");
      repeat (49) tick();
      chk(res_valid, 1'b0, "t3 no result at 49");
      tick();
      chk(res_valid,   1'b1, "t3 valid at 50");
      chk(res_nonce,   32'h0, "t3 nonce");
      chk(res_timeout, 1'b1, "t3 timeout");
      chk(res_id,      4'd4, "t3 id");
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      run_job(32'h2005, 2, 4'd5, 1'b1, "t3 next job");

      // Find and timeout on the same cycle: the find wins
      push_job(96'hC0, 8'h21);
      wait_run("t4");
      repeat (49) tick();
      chk(res_valid, 1'b0, "t4 no early result");
      miner_finished = 1'b1;
      miner_nonce    = 32'hDEAD_BEEF;
      tick();
      miner_finished = 1'b0;
      chk(res_valid,   1'b1, "t4 valid");
      chk(res_timeout, 1'b0, "t4 timeout");
      chk(res_nonce,   32'hDEAD_BEEF, "t4 nonce");
      chk(res_id,      4'd6, "t4 id");
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Back-pressure on the result port for 10 cycles with another job queued
      push_job(96'hD0, 8'h31);
      push_job(96'hD1, 8'h32);
      wait_run("t5");
      repeat (2) tick();
      miner_finished = 1'b1;
      miner_nonce    = 32'h0077_0077;
      tick();
      miner_finished = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk(res_valid,   1'b1, "t5 hold valid");
         chk(res_nonce,   32'h0077_0077, "t5 hold nonce");
         chk(res_id,      4'd7, "t5 hold id");
         chk(miner_reset, 1'b1, "t5 hold miner_reset");
         chk(miner_data,  96'hD0, "t5 hold miner_data");
         tick();
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      run_job(32'h3008, 1, 4'd8, 1'b1, "t5 job8");

      // IDs wrap 15 -> 0 on the 17th push since reset
      for (int i = 9; i <= 16; i++) begin
         push_job(96'hE0 + 96'(i), 8'h40);
         run_job(32'h4000 + 32'(i), 2, 4'(i), 1'b1, $sformatf("t6 wrap%0d", i));
      end

      // Asynchronous reset mid-RUN with jobs queued
      push_job(96'hF0, 8'h51);
      push_job(96'hF1, 8'h52);
      push_job(96'hF2, 8'h53);
      wait_run("t7");
      repeat (3) tick();
      #3;
      reset = 1'b1;
      #1;
      chk(res_valid,   1'b0, "t7 res_valid");
      chk(miner_reset, 1'b1, "t7 miner_reset");
      chk(job_ready,   1'b1, "t7 job_ready");
      chk(miner_data,  96'h0, "t7 miner_data");
      chk(res_nonce,   32'h0, "t7 res_nonce");
      tick();
      reset = 1'b0;
      repeat (5) tick();
      chk(miner_reset, 1'b1, "t7 fifo empty no launch");
      push_job(96'h55, 8'h66);
      run_job(32'h5000, 2, 4'd0, 1'b1, "t7 id restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
